vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter HS_POL, default 0: active level of vga_h_sync.
REQ-010 Parameter VS_POL, default 0: active level of vga_v_sync.
REQ-011 Parameter VS_ALIGN_HS, default 1: 1 = vsync edges coincide with hsync leading edge; 0 = vsync edges at X=0.
REQ-012 Parameter CNT_W, default 16: counter width.
REQ-013 Clk  input  1  single clock; all logic on rising edge.
REQ-014 Reset_n  input  1  asynchronous, active-low reset.
REQ-015 ce_pix  input  1  pixel clock enable; the timing position advances only on Clk edges with ce_pix=1.
REQ-016 vga_h_sync  output  1  horizontal sync, polarity HS_POL.
REQ-017 vga_v_sync  output  1  vertical sync, polarity VS_POL.
REQ-018 hblank  output  1  high when CounterX >= H_ACTIVE.
REQ-019 vblank  output  1  high when CounterY >= V_ACTIVE.
REQ-020 de  output  1  display enable: ~hblank & ~vblank.
REQ-021 line_start  output  1  one-Clk strobe on entering X=0.
REQ-022 frame_start  output  1  one-Clk strobe on entering (0,0).
REQ-023 CounterX  output  CNT_W  current pixel column.
REQ-024 CounterY  output  CNT_W  current line.

Function
REQ-025 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both must be at most 2^CNT_W; an elaboration error is raised otherwise.
REQ-026 On each Clk edge with ce_pix=1:
 - CounterX increments, and wraps to 0 after H_TOTAL-1.
 - On that wrap, CounterY increments, and wraps to 0 after V_TOTAL-1.
REQ-027 With ce_pix=0, CounterX, CounterY, syncs, blanks and de hold their values.
REQ-028 All outputs are registered; syncs, blanks and de present in a cycle describe the position shown on CounterX/CounterY in that same cycle (zero skew).
REQ-029 Horizontal sync is active for H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC.
REQ-030 Vertical sync, VS_ALIGN_HS=0: active for V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC, with edges at CounterX=0.
REQ-031 Vertical sync, VS_ALIGN_HS=1: the same line window, but edges are delayed to the cycle where CounterX = H_ACTIVE+H_FP.
REQ-032 line_start is high for exactly one Clk cycle after the ce_pix-qualified edge that moves CounterX to 0; it clears on the next Clk edge regardless of ce_pix.
REQ-033 frame_start behaves as line_start, restricted to the edge that moves the position to (0,0); it is coincident with line_start.
REQ-034 Next-state decode is computed from the current counters (compare-to-constant); no division and no multiplication.
REQ-035 Degenerate cases:
 - H_SYNC=0 or V_SYNC=0 leaves the corresponding sync permanently inactive.
 - Porch values of 0 are legal.

Reset
REQ-036 While Reset_n=0, outputs are forced asynchronously to:
 - CounterX=0, CounterY=0.
 - hblank=0, vblank=0, de=1.
 - vga_h_sync=~HS_POL, vga_v_sync=~VS_POL.
 - line_start=0, frame_start=0.
REQ-037 The first ce_pix edge after release moves CounterX to 1; no strobe is issued for the reset position (0,0).
REQ-038 Reset asserted mid-frame returns all outputs to the REQ-036 values immediately, with no partial sync pulse completed.

Verification
REQ-039 Defaults, ce_pix=1, run two frames -> exactly 800*525 Clk cycles between frame_start pulses; 525 line_start pulses per frame.
REQ-040 Defaults -> vga_h_sync low for CounterX 656..751 only; hblank high for 640..799; de high for 640*480 cycles per frame.
REQ-041 Defaults, VS_ALIGN_HS=1 -> vga_v_sync falls at (X=656, Y=490) and rises at (X=656, Y=492); with VS_ALIGN_HS=0 the edges are at (0,490) and (0,492).
REQ-042 ce_pix toggling 1,0,1,0 -> counters advance every second Clk; strobes are one Clk wide; frame period is 2*800*525 Clk.
REQ-043 H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=0, V_SYNC=1, V_BP=1, HS_POL=1 -> H_TOTAL=8, hsync high at X=5..6, vsync active at Y=2, frame period 32 Clk.
REQ-044 Reset_n pulsed low at (X=700, Y=491) -> outputs take the REQ-036 values without waiting for a Clk edge; after release, the next frame_start occurs after 800*525 ce edges.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered, zero-skew
// sync, blanking, display-enable and line/frame start strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter bit VS_ALIGN_HS = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             ce_pix,
    output logic             vga_h_sync,
    output logic             vga_v_sync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] CounterX,
    output logic [CNT_W-1:0] CounterY
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int CW       = CNT_W + 1;

    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    if (H_TOTAL > CNT_RANGE) begin : g_h_range_chk
        $error("vga_timing_gen: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > CNT_RANGE) begin : g_v_range_chk
        $error("vga_timing_gen: V_TOTAL exceeds counter range");
    end

    // Constants widened by one bit so that a total of exactly 2^CNT_W still fits.
    localparam logic [CNT_W:0] X_LAST_C   = CW'(H_TOTAL - 1);
    localparam logic [CNT_W:0] Y_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT_C    = CW'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT_C    = CW'(V_ACTIVE);
    localparam logic [CNT_W:0] HS_START_C = CW'(HS_START);
    localparam logic [CNT_W:0] HS_END_C   = CW'(HS_END);
    localparam logic [CNT_W:0] VS_START_C = CW'(VS_START);
    localparam logic [CNT_W:0] VS_END_C   = CW'(VS_END);

    // If the hsync leading edge never occurs within a line, align vsync to X=0.
    localparam bit VS_AT_HS = VS_ALIGN_HS && (HS_START < H_TOTAL);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] x_nx, y_nx;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             hb_q, hb_d, vb_q, vb_d, de_q, de_d;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic             x_wrap, y_wrap, hs_win, vs_win, vs_upd, hb_nx, vb_nx;

    always_comb begin
        x_wrap = ({1'b0, x_q} == X_LAST_C);
        y_wrap = ({1'b0, y_q} == Y_LAST_C);
        x_nx   = x_wrap ? '0 : x_q + CNT_W'(1);
        y_nx   = y_q;
        if (x_wrap) begin
            y_nx = y_wrap ? '0 : y_q + CNT_W'(1);
        end

        hs_win = ({1'b0, x_nx} >= HS_START_C) && ({1'b0, x_nx} < HS_END_C);
        vs_win = ({1'b0, y_nx} >= VS_START_C) && ({1'b0, y_nx} < VS_END_C);
        vs_upd = VS_AT_HS ? ({1'b0, x_nx} == HS_START_C) : (x_nx == '0);
        hb_nx  = ({1'b0, x_nx} >= H_ACT_C);
        vb_nx  = ({1'b0, y_nx} >= V_ACT_C);

        x_d  = x_q;
        y_d  = y_q;
        hs_d = hs_q;
        vs_d = vs_q;
        hb_d = hb_q;
        vb_d = vb_q;
        de_d = de_q;
        ls_d = 1'b0;
        fs_d = 1'b0;

        if (ce_pix) begin
            x_d  = x_nx;
            y_d  = y_nx;
            hs_d = hs_win ? HS_POL : ~HS_POL;
            if (vs_upd) begin
                vs_d = vs_win ? VS_POL : ~VS_POL;
            end
            hb_d = hb_nx;
            vb_d = vb_nx;
            de_d = ~hb_nx & ~vb_nx;
            ls_d = (x_nx == '0);
            fs_d = (x_nx == '0) && (y_nx == '0);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            hb_q <= 1'b0;
            vb_q <= 1'b0;
            de_q <= 1'b1;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            hb_q <= hb_d;
            vb_q <= vb_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign CounterX    = x_q;
    assign CounterY    = y_q;
    assign vga_h_sync  = hs_q;
    assign vga_v_sync  = vs_q;
    assign hblank      = hb_q;
    assign vblank      = vb_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing with a short
// vertical frame (both vsync alignments) plus a tiny 8x4 raster.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset_n;
    logic ce_pix;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    logic        a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
    logic [15:0] a_x, a_y;
    logic        b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
    logic [15:0] b_x, b_y;
    logic        c_hs, c_vs, c_hb, c_vb, c_de, c_ls, c_fs;
    logic [15:0] c_x, c_y;

    // Default horizontal timing, 10-line frame: V window 6..7.
    vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .ce_pix(ce_pix),
        .vga_h_sync(a_hs), .vga_v_sync(a_vs), .hblank(a_hb), .vblank(a_vb),
        .de(a_de), .line_start(a_ls), .frame_start(a_fs),
        .CounterX(a_x), .CounterY(a_y));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .VS_ALIGN_HS(1'b0)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .ce_pix(ce_pix),
        .vga_h_sync(b_hs), .vga_v_sync(b_vs), .hblank(b_hb), .vblank(b_vb),
        .de(b_de), .line_start(b_ls), .frame_start(b_fs),
        .CounterX(b_x), .CounterY(b_y));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .ce_pix(ce_pix),
        .vga_h_sync(c_hs), .vga_v_sync(c_vs), .hblank(c_hb), .vblank(c_vb),
        .de(c_de), .line_start(c_ls), .frame_start(c_fs),
        .CounterX(c_x), .CounterY(c_y));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_a_fs(input string name);
        int n = 0;
        while (a_fs !== 1'b1 && n < 9000) begin
            tick();
            n++;
        end
        checks++;
        if (a_fs !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait_frame_start got=%b exp=1 after %0d cycles", name, a_fs, n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        Reset_n = 1'b0;
        #2;
        checks++;
        if ({a_x, a_y} !== 32'd0) begin
            failures++; $display("FAIL reset_counters got=%h exp=0", {a_x, a_y});
        end
        checks++;
        if ({a_hb, a_vb, a_de, a_hs, a_vs, a_ls, a_fs} !== 7'b0011100) begin
            failures++; $display("FAIL reset_flags_a got=%b exp=0011100", {a_hb, a_vb, a_de, a_hs, a_vs, a_ls, a_fs});
        end
        checks++;
        if ({b_hb, b_vb, b_de, b_hs, b_vs, b_ls, b_fs} !== 7'b0011100) begin
            failures++; $display("FAIL reset_flags_b got=%b exp=0011100", {b_hb, b_vb, b_de, b_hs, b_vs, b_ls, b_fs});
        end
        checks++;
        if ({c_hs, c_vs} !== 2'b01) begin
            failures++; $display("FAIL reset_sync_pol_c got=%b exp=01", {c_hs, c_vs});
        end
        tick();
        checks++;
        if ({c_x, c_y} !== 32'd0) begin
            failures++; $display("FAIL reset_hold_c got=%h exp=0", {c_x, c_y});
        end
    endtask

    task automatic test_first_edge();
        Reset_n = 1'b1;
        tick();
        checks++;
        if (a_x !== 16'd1 || a_y !== 16'd0) begin
            failures++; $display("FAIL first_edge_pos got=(%0d,%0d) exp=(1,0)", a_x, a_y);
        end
        checks++;
        if ({a_ls, a_fs, c_ls, c_fs} !== 4'b0000) begin
            failures++; $display("FAIL first_edge_strobes got=%b exp=0000", {a_ls, a_fs, c_ls, c_fs});
        end
        checks++;
        if (c_x !== 16'd1) begin
            failures++; $display("FAIL first_edge_c_x got=%0d exp=1", c_x);
        end
    endtask

    task automatic test_hline();
        int ex = 1;
        int pos_err = 0, hs_first = -1, hs_last = -1, hs_cnt = 0;
        int hb_first = -1, hb_cnt = 0, de_cnt = 0, ls_cnt = 0, ls_x = -1;
        for (int i = 0; i < 800; i++) begin
            if (a_x !== 16'(ex)) pos_err++;
            if (a_hs == 1'b0) begin
                if (hs_first < 0) hs_first = ex;
                hs_last = ex;
                hs_cnt++;
            end
            if (a_hb) begin
                if (hb_first < 0) hb_first = ex;
                hb_cnt++;
            end
            if (a_de) de_cnt++;
            if (a_ls) begin
                ls_cnt++;
                ls_x = int'(a_x);
            end
            tick();
            ex = (ex + 1) % 800;
        end
        checks++; if (pos_err != 0) begin failures++; $display("FAIL hline_counter_x got=%0d_errors exp=0", pos_err); end
        checks++; if (hs_first != 656) begin failures++; $display("FAIL hline_hs_first got=%0d exp=656", hs_first); end
        checks++; if (hs_last != 751) begin failures++; $display("FAIL hline_hs_last got=%0d exp=751", hs_last); end
        checks++; if (hs_cnt != 96) begin failures++; $display("FAIL hline_hs_width got=%0d exp=96", hs_cnt); end
        checks++; if (hb_first != 640) begin failures++; $display("FAIL hline_hblank_first got=%0d exp=640", hb_first); end
        checks++; if (hb_cnt != 160) begin failures++; $display("FAIL hline_hblank_width got=%0d exp=160", hb_cnt); end
        checks++; if (de_cnt != 640) begin failures++; $display("FAIL hline_de_count got=%0d exp=640", de_cnt); end
        checks++; if (ls_cnt != 1 || ls_x != 0) begin failures++; $display("FAIL hline_line_start got=%0d@x%0d exp=1@x0", ls_cnt, ls_x); end
    endtask

    task automatic test_frame();
        int c = 0, ls_cnt = 0, de_cnt = 0, vb_cnt = 0;
        wait_a_fs("frame");
        checks++;
        if ({a_ls, a_x, a_y} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL frame_start_coincident got=ls%b(%0d,%0d) exp=ls1(0,0)", a_ls, a_x, a_y);
        end
        do begin
            if (a_ls) ls_cnt++;
            if (a_de) de_cnt++;
            if (a_vb) vb_cnt++;
            tick();
            c++;
        end while (a_fs !== 1'b1 && c < 9000);
        checks++; if (c != 8000) begin failures++; $display("FAIL frame_period got=%0d exp=8000", c); end
        checks++; if (ls_cnt != 10) begin failures++; $display("FAIL frame_line_starts got=%0d exp=10", ls_cnt); end
        checks++; if (de_cnt != 2560) begin failures++; $display("FAIL frame_de_count got=%0d exp=2560", de_cnt); end
        checks++; if (vb_cnt != 4800) begin failures++; $display("FAIL frame_vblank_count got=%0d exp=4800", vb_cnt); end
    endtask

    task automatic test_vsync_align();
        logic pa, pb;
        int a_fx = -1, a_fy = -1, a_rx = -1, a_ry = -1, a_edges = 0;
        int b_fx = -1, b_fy = -1, b_rx = -1, b_ry = -1, b_edges = 0;
        wait_a_fs("vsync");
        pa = a_vs;
        pb = b_vs;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (a_vs !== pa) begin
                a_edges++;
                if (a_vs == 1'b0) begin a_fx = int'(a_x); a_fy = int'(a_y); end
                else begin a_rx = int'(a_x); a_ry = int'(a_y); end
            end
            if (b_vs !== pb) begin
                b_edges++;
                if (b_vs == 1'b0) begin b_fx = int'(b_x); b_fy = int'(b_y); end
                else begin b_rx = int'(b_x); b_ry = int'(b_y); end
            end
            pa = a_vs;
            pb = b_vs;
        end
        checks++; if (a_fx != 656 || a_fy != 6) begin failures++; $display("FAIL vs_align_fall got=(%0d,%0d) exp=(656,6)", a_fx, a_fy); end
        checks++; if (a_rx != 656 || a_ry != 8) begin failures++; $display("FAIL vs_align_rise got=(%0d,%0d) exp=(656,8)", a_rx, a_ry); end
        checks++; if (b_fx != 0 || b_fy != 6) begin failures++; $display("FAIL vs_x0_fall got=(%0d,%0d) exp=(0,6)", b_fx, b_fy); end
        checks++; if (b_rx != 0 || b_ry != 8) begin failures++; $display("FAIL vs_x0_rise got=(%0d,%0d) exp=(0,8)", b_rx, b_ry); end
        checks++; if (a_edges != 2 || b_edges != 2) begin failures++; $display("FAIL vs_edge_count got=%0d/%0d exp=2/2", a_edges, b_edges); end
    endtask

    task automatic test_ce_toggle();
        int c = 0, ls_cnt = 0, hold_err = 0, adv_err = 0, px;
        logic phs, phb;
        wait_a_fs("ce_toggle");
        do begin
            ce_pix = ~ce_pix;
            px  = int'(a_x);
            phs = a_hs;
            phb = a_hb;
            tick();
            c++;
            if (ce_pix == 1'b0) begin
                if (a_x !== 16'(px) || a_hs !== phs || a_hb !== phb || a_ls !== 1'b0) hold_err++;
            end else if (a_x !== 16'((px == 799) ? 0 : px + 1)) begin
                adv_err++;
            end
            if (a_ls) ls_cnt++;
        end while (a_fs !== 1'b1 && c < 40000);
        ce_pix = 1'b1;
        checks++; if (c != 16000) begin failures++; $display("FAIL ce_frame_period got=%0d exp=16000", c); end
        checks++; if (ls_cnt != 10) begin failures++; $display("FAIL ce_strobe_width got=%0d exp=10", ls_cnt); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL ce_hold got=%0d_errors exp=0", hold_err); end
        checks++; if (adv_err != 0) begin failures++; $display("FAIL ce_advance got=%0d_errors exp=0", adv_err); end
    endtask

    task automatic test_small();
        int n = 0, hs_cnt = 0, hs_min = 99, hs_max = -1, hb_cnt = 0, vb_cnt = 0, de_cnt = 0, fs_mid = 0;
        int fx = -1, fy = -1, rx = -1, ry = -1;
        logic pv;
        while (c_fs !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (c_fs !== 1'b1) begin failures++; $display("FAIL small_wait_frame_start got=%b exp=1", c_fs); end
        pv = c_vs;
        for (int i = 0; i < 32; i++) begin
            if (i > 0 && c_fs) fs_mid++;
            if (c_hs) begin
                hs_cnt++;
                if (int'(c_x) < hs_min) hs_min = int'(c_x);
                if (int'(c_x) > hs_max) hs_max = int'(c_x);
            end
            if (c_hb) hb_cnt++;
            if (c_vb) vb_cnt++;
            if (c_de) de_cnt++;
            if (c_vs !== pv) begin
                if (c_vs == 1'b0) begin fx = int'(c_x); fy = int'(c_y); end
                else begin rx = int'(c_x); ry = int'(c_y); end
            end
            pv = c_vs;
            tick();
        end
        checks++; if (c_fs !== 1'b1 || fs_mid != 0) begin failures++; $display("FAIL small_period got=fs%b_mid%0d exp=fs1_mid0", c_fs, fs_mid); end
        checks++; if (hs_cnt != 8 || hs_min != 5 || hs_max != 6) begin failures++; $display("FAIL small_hsync got=%0d@%0d..%0d exp=8@5..6", hs_cnt, hs_min, hs_max); end
        checks++; if (hb_cnt != 16 || vb_cnt != 16 || de_cnt != 8) begin failures++; $display("FAIL small_blank got=hb%0d_vb%0d_de%0d exp=hb16_vb16_de8", hb_cnt, vb_cnt, de_cnt); end
        checks++; if (fx != 5 || fy != 2 || rx != 5 || ry != 3) begin failures++; $display("FAIL small_vsync got=(%0d,%0d)-(%0d,%0d) exp=(5,2)-(5,3)", fx, fy, rx, ry); end
    endtask

    task automatic test_midframe_reset();
        int n = 0, c = 0;
        while (!(a_x == 16'd700 && a_y == 16'd7) && n < 9000) begin tick(); n++; end
        checks++;
        if ({a_hs, a_vs, a_hb, a_vb} !== 4'b0011 || a_x !== 16'd700) begin
            failures++; $display("FAIL midframe_precondition got=%b@x%0d exp=0011@x700", {a_hs, a_vs, a_hb, a_vb}, a_x);
        end
        Reset_n = 1'b0;
        #2;
        checks++;
        if ({a_x, a_y} !== 32'd0) begin
            failures++; $display("FAIL midframe_async_counters got=%h exp=0", {a_x, a_y});
        end
        checks++;
        if ({a_hb, a_vb, a_de, a_hs, a_vs, a_ls, a_fs} !== 7'b0011100) begin
            failures++; $display("FAIL midframe_async_flags got=%b exp=0011100", {a_hb, a_vb, a_de, a_hs, a_vs, a_ls, a_fs});
        end
        tick();
        tick();
        Reset_n = 1'b1;
        do begin
            tick();
            c++;
        end while (a_fs !== 1'b1 && c < 9000);
        checks++; if (c != 8000) begin failures++; $display("FAIL midframe_next_frame got=%0d exp=8000", c); end
    endtask

    initial begin
        Reset_n = 1'b1;
        ce_pix  = 1'b1;
        test_reset();
        test_first_edge();
        test_hline();
        test_frame();
        test_vsync_align();
        test_ce_toggle();
        test_small();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
